// File: rtl/gate_ex_pkg.sv
// -----------------------------------------------------------------------------
// gate_ex_pkg
//   Shared types and constants for the 2-input gate exerciser.
//   - state_e     : exerciser FSM states (2-bit encoding)
//   - NUM_VECTORS : number of input combinations for a 2-input gate
//   - TT_*        : truth tables, bit index = {a,b}
// -----------------------------------------------------------------------------
package gate_ex_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage : gate_ex_pkg

// File: rtl/gate_exerciser_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Counts the cycles the gate inputs have been held in the SETTLE state.
//   The counter restarts from zero whenever load is high and advances while
//   en is high, stopping at SETTLE_CYCLES-1 where expire is asserted.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   load   in   restart the count at zero
//   en     in   advance the count (ignored while load is high)
//   expire out  count has reached SETTLE_CYCLES-1 (combinational decode)
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  // Count spans 0..SETTLE_CYCLES-1; keep at least one bit for SETTLE_CYCLES=1.
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q == LAST);

endmodule : settle_timer

// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
//   Clocked stimulus/response sequencer for a 2-input combinational gate.
//   Drives a/b through {11,10,01,00}, holds each vector SETTLE_CYCLES cycles,
//   samples r for one CHECK cycle and compares it against EXPECTED[{a,b}].
//
// Parameters:
//   EXPECTED      truth table, bit index = {a,b} (default OR)
//   SETTLE_CYCLES cycles a/b are held before r is sampled (1..255)
//   ERR_W         width of err_count (>= 3)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a run; only sampled in IDLE
//   r          in   gate output under test
//   a, b       out  gate inputs, registered
//   busy       out  high while a run is in progress (SETTLE/CHECK/FINISH)
//   done       out  one-cycle pulse in FINISH
//   pass       out  run result, valid with done, held until next start
//   err_count  out  saturating mismatch count, held like pass
//   fail_vec   out  bit i set if vector {a,b}=i mismatched, held like pass
// -----------------------------------------------------------------------------
module gate_exerciser
  import gate_ex_pkg::*;
#(
  parameter logic [3:0]  EXPECTED      = TT_OR,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             r,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam logic [1:0]       FIRST_IDX = 2'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_e     state_q;
  state_e     state_d;
  logic [1:0] idx_q;
  logic       settle_done;
  logic       mismatch;
  logic [3:0] fail_next;

  // ---------------------------------------------------------------------------
  // Settle timer: restarts whenever we are outside SETTLE, so each vector
  // begins its hold period from zero.
  // ---------------------------------------------------------------------------
  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q != SETTLE),
    .en     (state_q == SETTLE),
    .expire (settle_done)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = CHECK;
      CHECK:   state_d = (idx_q == 2'd0) ? FINISH : SETTLE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare. Case-inequality makes an X/Z on r count as a mismatch in
  // simulation; in hardware it reduces to an ordinary inequality.
  // ---------------------------------------------------------------------------
  always_comb begin
    mismatch  = (r !== EXPECTED[idx_q]);
    fail_next = fail_vec;
    if (mismatch) fail_next[idx_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Vector index, gate drive and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            idx_q     <= FIRST_IDX;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        SETTLE: begin
          a <= idx_q[1];
          b <= idx_q[0];
        end
        CHECK: begin
          if (mismatch) begin
            fail_vec <= fail_next;
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          end
          // pass is resolved on the final compare so it is already valid
          // during the FINISH cycle alongside done.
          if (idx_q == 2'd0) begin
            pass <= (fail_next == 4'b0000);
          end else begin
            idx_q <= idx_q - 2'd1;
          end
        end
        FINISH: ;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule : gate_exerciser

// File: tb/tb_gate_exerciser.sv
// -----------------------------------------------------------------------------
// tb_gate_exerciser
//   Two exerciser instances:
//     dut_a : EXPECTED=TT_OR,  SETTLE_CYCLES=1, gate selected by mode_a
//     dut_b : EXPECTED=TT_AND, SETTLE_CYCLES=3, gate selected by mode_b
//   Expected run results come from a small truth-table model and are pushed
//   onto per-DUT scoreboards when a run is launched, then popped on done.
// -----------------------------------------------------------------------------
module tb_gate_exerciser;
  import gate_ex_pkg::*;

  typedef enum logic [1:0] {G_OR, G_AND, G_ZERO} gate_e;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [3:0] fv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  gate_e      mode_a, mode_b;
  logic       r_a, r_b;
  logic       a_a, b_a, busy_a, done_a, pass_a;
  logic       a_b, b_b, busy_b, done_b, pass_b;
  logic [2:0] err_a, err_b;
  logic [3:0] fv_a, fv_b;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;

  function automatic logic gate_fn(input gate_e g, input logic x, input logic y);
    case (g)
      G_OR:    return x | y;
      G_AND:   return x & y;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: which vectors a given gate fails against a truth table.
  function automatic exp_t model(input gate_e g, input logic [3:0] tt);
    exp_t       e;
    logic [1:0] v;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (gate_fn(g, v[1], v[0]) !== tt[i]) begin
        e.fv[i] = 1'b1;
        if (e.err != 3'd7) e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.fv == 4'b0000);
    return e;
  endfunction

  assign r_a = gate_fn(mode_a, a_a, b_a);
  assign r_b = gate_fn(mode_b, a_b, b_b);

  gate_exerciser #(
    .EXPECTED      (TT_OR),
    .SETTLE_CYCLES (1),
    .ERR_W         (3)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .r         (r_a),
    .a         (a_a),
    .b         (b_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .err_count (err_a),
    .fail_vec  (fv_a)
  );

  gate_exerciser #(
    .EXPECTED      (TT_AND),
    .SETTLE_CYCLES (3),
    .ERR_W         (3)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .r         (r_b),
    .a         (a_b),
    .b         (b_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .err_count (err_b),
    .fail_vec  (fv_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a} !== 12'h000) begin
        errors++;
        $display("FAIL reset_a: got %03h expected 000",
                 {a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a});
      end
      checks++;
      if ({a_b, b_b, busy_b, done_b, pass_b, err_b, fv_b} !== 12'h000) begin
        errors++;
        $display("FAIL reset_b: got %03h expected 000",
                 {a_b, b_b, busy_b, done_b, pass_b, err_b, fv_b});
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_run: got busy %b%b expected 00", busy_a, busy_b);
    end
  endtask

  // Launch one run on dut_a with a start pulse and score it against the model.
  task automatic run_a(input gate_e mode, input bit check_ab, input string name);
    int         lat;
    int         v;
    exp_t       e;
    logic [1:0] exp_ab;
    mode_a = mode;
    sb_a.push_back(model(mode, TT_OR));
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, pass_a, err_a, fv_a} !== 9'h100) begin
      errors++;
      $display("FAIL %s_clear: got %03h expected 100", name, {busy_a, pass_a, err_a, fv_a});
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (check_ab && k <= 8) begin
        v      = 3 - (k - 1) / 2;
        exp_ab = 2'(v);
        checks++;
        if ({a_a, b_a} !== exp_ab) begin
          errors++;
          $display("FAIL %s_ab%0d: got %b expected %b", name, k, {a_a, b_a}, exp_ab);
        end
      end
      if (done_a === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 8", name, lat);
    end
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      checks++;
      if (pass_a !== e.pass) begin
        errors++;
        $display("FAIL %s_pass: got %b expected %b", name, pass_a, e.pass);
      end
      checks++;
      if (err_a !== e.err) begin
        errors++;
        $display("FAIL %s_err: got %0d expected %0d", name, err_a, e.err);
      end
      checks++;
      if (fv_a !== e.fv) begin
        errors++;
        $display("FAIL %s_fail_vec: got %b expected %b", name, fv_a, e.fv);
      end
      @(negedge clk);
      checks++;
      if ({done_a, busy_a, pass_a, err_a, fv_a} !== {2'b00, e.pass, e.err, e.fv}) begin
        errors++;
        $display("FAIL %s_hold: got %03h expected %03h", name,
                 {done_a, busy_a, pass_a, err_a, fv_a}, {2'b00, e.pass, e.err, e.fv});
      end
    end
  endtask

  task automatic test_or_pass();
    run_a(G_OR, 1'b1, "or_pass");
  endtask

  task automatic test_zero_gate();
    run_a(G_ZERO, 1'b0, "zero_gate");
  endtask

  task automatic test_and_vs_or();
    run_a(G_AND, 1'b0, "and_vs_or");
  endtask

  // Single start pulse on dut_b: and gate against TT_AND with a 3-cycle settle.
  task automatic test_and_pass();
    int   lat;
    exp_t e;
    mode_b = G_AND;
    sb_b.push_back(model(G_AND, TT_AND));
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = -1;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL and_pass_latency: got %0d expected 16", lat);
    end
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      checks++;
      if ({pass_b, err_b, fv_b} !== {e.pass, e.err, e.fv}) begin
        errors++;
        $display("FAIL and_pass_result: got %02h expected %02h",
                 {pass_b, err_b, fv_b}, {e.pass, e.err, e.fv});
      end
    end
  endtask

  // start held high on dut_b: back-to-back runs 18 cycles apart.
  task automatic test_back_to_back();
    int   ndone;
    int   last_done;
    int   low_run;
    exp_t e;
    mode_b = G_AND;
    for (int i = 0; i < 3; i++) sb_b.push_back(model(G_AND, TT_AND));
    @(negedge clk);
    start_b   = 1'b1;
    ndone     = 0;
    last_done = -1;
    low_run   = 0;
    for (int c = 0; c < 100 && ndone < 3; c++) begin
      @(negedge clk);
      if (busy_b === 1'b0) begin
        low_run++;
      end else if (low_run > 0) begin
        checks++;
        if (low_run != 1) begin
          errors++;
          $display("FAIL b2b_idle_gap: got %0d expected 1", low_run);
        end
        checks++;
        if ({pass_b, err_b, fv_b} !== 8'h00) begin
          errors++;
          $display("FAIL b2b_clear: got %02h expected 00", {pass_b, err_b, fv_b});
        end
        low_run = 0;
      end
      if (done_b === 1'b1) begin
        checks++;
        if (last_done < 0) begin
          if (c != 16) begin
            errors++;
            $display("FAIL b2b_first_done: got %0d expected 16", c);
          end
        end else if (c - last_done != 18) begin
          errors++;
          $display("FAIL b2b_period: got %0d expected 18", c - last_done);
        end
        last_done = c;
        ndone++;
        if (sb_b.size() > 0) begin
          e = sb_b.pop_front();
          checks++;
          if ({pass_b, err_b, fv_b} !== {e.pass, e.err, e.fv}) begin
            errors++;
            $display("FAIL b2b_result: got %02h expected %02h",
                     {pass_b, err_b, fv_b}, {e.pass, e.err, e.fv});
          end
        end
        if (ndone == 3) start_b = 1'b0;
      end
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 3", ndone);
    end
    start_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy %b expected 0", busy_b);
    end
  endtask

  // Reset asserted while dut_a is in SETTLE for idx=1 with errors already logged.
  task automatic test_mid_reset();
    int saw_done;
    mode_a = G_ZERO;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    checks++;
    if ({busy_a, a_a, b_a, err_a} !== {3'b110, 3'd2}) begin
      errors++;
      $display("FAIL mid_reset_pre: got %02h expected %02h",
               {busy_a, a_a, b_a, err_a}, {3'b110, 3'd2});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_async: got %03h expected 000",
               {a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a});
    end
    saw_done = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) saw_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d expected 0", saw_done);
    end
    run_a(G_OR, 1'b1, "post_reset");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    mode_a  = G_OR;
    mode_b  = G_AND;
    test_reset();
    test_or_pass();
    test_zero_gate();
    test_or_pass();
    test_and_vs_or();
    test_and_pass();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gate_exerciser

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Self-checking stimulus/response sequencer for a 2-input combinational gate DUT (or_gate, and_gate, etc.).
- Drives the gate inputs a/b through all four input combinations and samples the gate output r after a settle time.
- Compares each sample against a parameterised truth table and reports the error count, a per-vector fail mask, and pass/done.
- Sits directly upstream (drives a, b) and downstream (consumes r) of the gate. This is the clocked, synthesisable replacement for hand-written initial-block stimulus.

Parameters:
- EXPECTED, 4'b1110, truth table; bit index = {a,b}; default is OR.
- SETTLE_CYCLES, 1, cycles a/b are held before r is sampled; legal range 1..255.
- ERR_W, 3, width of err_count; minimum 3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a test run; sampled in IDLE only.
- r  in  1  gate output under test.
- a  out  1  gate input A, registered.
- b  out  1  gate input B, registered.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse at end of run.
- pass  out  1  run result; held until next accepted start or reset.
- err_count  out  ERR_W  mismatch count; saturating; held like pass.
- fail_vec  out  4  bit i set if vector {a,b}=i mismatched; held like pass.

Behaviour:
- Reset (async assert, sync-deasserted externally): state=IDLE; a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- State machine states: IDLE, SETTLE, CHECK, FINISH.
- IDLE:
  - a=b=0, busy=0.
  - start=1 → SETTLE; idx=3; settle_cnt=0; clear pass, err_count and fail_vec.
- SETTLE:
  - busy=1; a=idx[1], b=idx[0], registered.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 → CHECK.
- CHECK (one cycle):
  - a/b unchanged; r sampled.
  - If r != EXPECTED[idx]: err_count+1 (saturating at 2^ERR_W-1) and fail_vec[idx]=1.
  - An r of X/Z in simulation counts as a mismatch (case-inequality).
  - If idx==0 → FINISH; else idx-1, settle_cnt=0 → SETTLE.
- FINISH (one cycle): done=1; pass=(fail_vec after final CHECK == 0); busy=1; → IDLE.
- Vector order is fixed: 11, 10, 01, 00.
- Latency: start accepted at edge N → first a/b valid after N+1 → done high in cycle N+4*(SETTLE_CYCLES+1)+1. For SETTLE_CYCLES=1 this is 9 cycles.
- start outside IDLE is ignored, including start held high. start high on the IDLE cycle after FINISH launches a new run immediately; results clear on acceptance.
- done is never high in IDLE except via FINISH, and is never asserted twice per run.
- Reset mid-run: immediate return to IDLE with all reset values; no done pulse; partial results are discarded.
- r is used only in CHECK; its value in other states has no effect.

Decomposition:
- Package gate_ex_pkg:
  - state enum (IDLE, SETTLE, CHECK, FINISH), 2-bit.
  - NUM_VECTORS=4.
  - Truth-table constants: TT_OR=4'b1110, TT_AND=4'b1000, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- One sub-module is natural: settle_timer (load/count/expire, width from SETTLE_CYCLES). The FSM, idx, result registers and compare stay in gate_exerciser.

Test Plan:
- Reset: rst_n=0 mid-idle with start=1 → a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; no run starts while rst_n=0.
- Correct or_gate, EXPECTED=TT_OR, SETTLE_CYCLES=1, start pulse at cycle 0 →
  - a/b = 11,10,01,00, each held 2 cycles.
  - done pulse in cycle 9.
  - pass=1, err_count=0, fail_vec=4'b0000.
- r tied 0, EXPECTED=TT_OR → err_count=3, fail_vec=4'b1110, pass=0.
- and_gate DUT, EXPECTED=TT_OR → err_count=2, fail_vec=4'b0110, pass=0. Then rerun with EXPECTED=TT_AND → pass=1.
- start held high continuously, SETTLE_CYCLES=3 →
  - done pulses every 18 cycles: 17-cycle run plus the 1-cycle IDLE.
  - busy low exactly 1 cycle between runs.
  - results cleared at each acceptance.
- rst_n pulsed low while idx=1 in SETTLE → outputs go to reset values asynchronously; no done; next start runs a full clean 4-vector sequence.
